// File: rtl/csr_unit_if.sv
// CSR access bus between the execute stage and the machine-mode CSR file.
// The execute stage drives address/op/data and receives pre-write read data and the illegal flag.
interface csr_unit_if;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic        csr_src_zero;
    logic [31:0] csr_rdata;
    logic        csr_illegal;

    modport master (
        output csr_addr, csr_op, csr_wdata, csr_src_zero,
        input  csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_addr, csr_op, csr_wdata, csr_src_zero,
        output csr_rdata, csr_illegal
    );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file: Zicsr read-modify-write, trap entry/return bookkeeping,
// and the 64-bit mcycle/minstret counters.
module csr_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    csr_unit_if.slave   csr,
    input  logic        trap_en,
    input  logic        trap_return,
    input  logic [31:0] mepc_in,
    input  logic [31:0] mcause_in,
    input  logic [31:0] mtval_in,
    input  logic        ext_irq,
    input  logic        time_irq,
    input  logic        soft_irq,
    input  logic        instr_retire,
    output logic [31:0] mtvec_r,
    output logic [31:0] mstatus_r,
    output logic [31:0] mepc_r,
    output logic [31:0] mie_r
);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_MSTATUS,
        SEL_MISA,
        SEL_MIE,
        SEL_MTVEC,
        SEL_MSCRATCH,
        SEL_MEPC,
        SEL_MCAUSE,
        SEL_MTVAL,
        SEL_MIP,
        SEL_MCYCLE,
        SEL_MCYCLEH,
        SEL_MINSTRET,
        SEL_MINSTRETH,
        SEL_ID
    } csr_sel_t;

    logic        mstatus_mie_reg, mstatus_mie_next;
    logic        mstatus_mpie_reg, mstatus_mpie_next;
    logic [31:0] mie_reg, mie_next;
    logic [31:0] mtvec_reg, mtvec_next;
    logic [31:0] mscratch_reg, mscratch_next;
    logic [31:0] mepc_reg, mepc_next;
    logic [31:0] mcause_reg, mcause_next;
    logic [31:0] mtval_reg, mtval_next;
    logic [63:0] mcycle_reg, mcycle_next;
    logic [63:0] minstret_reg, minstret_next;
    logic [2:0]  irq_sync_reg;

    logic [31:0] mstatus_value;
    logic [31:0] mip_value;
    logic [2:0]  irq_lines;

    csr_sel_t    sel;
    logic [31:0] old_value;
    logic [31:0] wmask;
    logic [31:0] rmw_value;
    logic [31:0] wr_value;
    logic        write_attempt;
    logic        illegal;
    logic        commit;

    assign mstatus_value = MSTATUS_FIXED
                         | {24'b0, mstatus_mpie_reg, 3'b0, mstatus_mie_reg, 3'b0};

    // mip bits 3/7/11 mirror soft/time/ext one cycle late; every other bit is hardwired 0.
    assign irq_lines = {ext_irq, time_irq, soft_irq};
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_mip
            if ((gi % 4 == 3) && (gi < 12)) begin : g_live
                assign mip_value[gi] = irq_sync_reg[gi / 4];
            end else begin : g_zero
                assign mip_value[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        sel       = SEL_NONE;
        old_value = 32'h0;
        wmask     = 32'h0;
        unique casez (csr.csr_addr)
            12'h300: begin sel = SEL_MSTATUS;   old_value = mstatus_value;       wmask = 32'h0000_0088; end
            12'h301: begin sel = SEL_MISA;      old_value = MISA_VAL;            wmask = 32'h0;         end
            12'h304: begin sel = SEL_MIE;       old_value = mie_reg;             wmask = 32'h0000_0888; end
            12'h305: begin sel = SEL_MTVEC;     old_value = mtvec_reg;           wmask = 32'hFFFF_FFFD; end
            12'h340: begin sel = SEL_MSCRATCH;  old_value = mscratch_reg;        wmask = 32'hFFFF_FFFF; end
            12'h341: begin sel = SEL_MEPC;      old_value = mepc_reg;            wmask = 32'hFFFF_FFFC; end
            12'h342: begin sel = SEL_MCAUSE;    old_value = mcause_reg;          wmask = 32'hFFFF_FFFF; end
            12'h343: begin sel = SEL_MTVAL;     old_value = mtval_reg;           wmask = 32'hFFFF_FFFF; end
            12'h344: begin sel = SEL_MIP;       old_value = mip_value;           wmask = 32'h0;         end
            12'hB00: begin sel = SEL_MCYCLE;    old_value = mcycle_reg[31:0];    wmask = 32'hFFFF_FFFF; end
            12'hB80: begin sel = SEL_MCYCLEH;   old_value = mcycle_reg[63:32];   wmask = 32'hFFFF_FFFF; end
            12'hB02: begin sel = SEL_MINSTRET;  old_value = minstret_reg[31:0];  wmask = 32'hFFFF_FFFF; end
            12'hB82: begin sel = SEL_MINSTRETH; old_value = minstret_reg[63:32]; wmask = 32'hFFFF_FFFF; end
            12'hF11, 12'hF12, 12'hF13:
                     begin sel = SEL_ID;        old_value = 32'h0;               wmask = 32'h0;         end
            12'hF14: begin sel = SEL_ID;        old_value = HART_ID;             wmask = 32'h0;         end
            default: begin sel = SEL_NONE;      old_value = 32'h0;               wmask = 32'h0;         end
        endcase
    end

    // RS/RC with a zero source are pure reads, so they may legally target read-only IDs.
    assign write_attempt = (csr.csr_op == OP_RW)
                         || ((csr.csr_op != OP_NONE) && !csr.csr_src_zero);
    assign illegal = (csr.csr_op != OP_NONE)
                   && ((sel == SEL_NONE) || ((sel == SEL_ID) && write_attempt));
    assign commit  = write_attempt && !illegal && !trap_en && !trap_return;

    always_comb begin
        rmw_value = old_value;
        case (csr.csr_op)
            OP_RW:   rmw_value = csr.csr_wdata;
            OP_RS:   rmw_value = old_value | csr.csr_wdata;
            OP_RC:   rmw_value = old_value & ~csr.csr_wdata;
            default: rmw_value = old_value;
        endcase
    end

    assign wr_value        = rmw_value & wmask;
    assign csr.csr_rdata   = ((csr.csr_op == OP_NONE) || illegal) ? 32'h0 : old_value;
    assign csr.csr_illegal = illegal;

    always_comb begin
        mstatus_mie_next  = mstatus_mie_reg;
        mstatus_mpie_next = mstatus_mpie_reg;
        mie_next          = mie_reg;
        mtvec_next        = mtvec_reg;
        mscratch_next     = mscratch_reg;
        mepc_next         = mepc_reg;
        mcause_next       = mcause_reg;
        mtval_next        = mtval_reg;

        if (trap_en) begin
            mepc_next         = mepc_in & 32'hFFFF_FFFC;
            mcause_next       = mcause_in;
            mtval_next        = mtval_in;
            mstatus_mpie_next = mstatus_mie_reg;
            mstatus_mie_next  = 1'b0;
        end else if (trap_return) begin
            mstatus_mie_next  = mstatus_mpie_reg;
            mstatus_mpie_next = 1'b1;
        end else if (commit) begin
            case (sel)
                SEL_MSTATUS: begin
                    mstatus_mie_next  = wr_value[3];
                    mstatus_mpie_next = wr_value[7];
                end
                SEL_MIE:      mie_next      = wr_value;
                SEL_MTVEC:    mtvec_next    = wr_value;
                SEL_MSCRATCH: mscratch_next = wr_value;
                SEL_MEPC:     mepc_next     = wr_value;
                SEL_MCAUSE:   mcause_next   = wr_value;
                SEL_MTVAL:    mtval_next    = wr_value;
                default:      ;
            endcase
        end
    end

    // A write to either counter half replaces that cycle's increment.
    always_comb begin
        mcycle_next = mcycle_reg + 64'd1;
        if (commit && (sel == SEL_MCYCLE)) begin
            mcycle_next = {mcycle_reg[63:32], wr_value};
        end else if (commit && (sel == SEL_MCYCLEH)) begin
            mcycle_next = {wr_value, mcycle_reg[31:0]};
        end

        minstret_next = minstret_reg;
        if (commit && (sel == SEL_MINSTRET)) begin
            minstret_next = {minstret_reg[63:32], wr_value};
        end else if (commit && (sel == SEL_MINSTRETH)) begin
            minstret_next = {wr_value, minstret_reg[31:0]};
        end else if (instr_retire && !trap_en) begin
            minstret_next = minstret_reg + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_reg  <= 1'b0;
            mstatus_mpie_reg <= 1'b0;
            mie_reg          <= 32'h0;
            mtvec_reg        <= MTVEC_RESET & 32'hFFFF_FFFD;
            mscratch_reg     <= 32'h0;
            mepc_reg         <= 32'h0;
            mcause_reg       <= 32'h0;
            mtval_reg        <= 32'h0;
            mcycle_reg       <= 64'h0;
            minstret_reg     <= 64'h0;
            irq_sync_reg     <= 3'b000;
        end else begin
            mstatus_mie_reg  <= mstatus_mie_next;
            mstatus_mpie_reg <= mstatus_mpie_next;
            mie_reg          <= mie_next;
            mtvec_reg        <= mtvec_next;
            mscratch_reg     <= mscratch_next;
            mepc_reg         <= mepc_next;
            mcause_reg       <= mcause_next;
            mtval_reg        <= mtval_next;
            mcycle_reg       <= mcycle_next;
            minstret_reg     <= minstret_next;
            irq_sync_reg     <= irq_lines;
        end
    end

    assign mtvec_r   = mtvec_reg;
    assign mstatus_r = mstatus_value;
    assign mepc_r    = mepc_reg;
    assign mie_r     = mie_reg;

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: each task drives one feature and checks against hand-computed values.
module tb_csr_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trap_en = 1'b0;
    logic        trap_return = 1'b0;
    logic [31:0] mepc_in = 32'h0;
    logic [31:0] mcause_in = 32'h0;
    logic [31:0] mtval_in = 32'h0;
    logic        ext_irq = 1'b0;
    logic        time_irq = 1'b0;
    logic        soft_irq = 1'b0;
    logic        instr_retire = 1'b0;
    logic [31:0] mtvec_r, mstatus_r, mepc_r, mie_r;

    int n_cmp = 0;
    int n_bad = 0;

    csr_unit_if bus ();

    csr_unit #(
        .MTVEC_RESET(32'h0000_1000),
        .MISA_VAL   (32'h4000_0100),
        .HART_ID    (32'd3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .csr         (bus),
        .trap_en     (trap_en),
        .trap_return (trap_return),
        .mepc_in     (mepc_in),
        .mcause_in   (mcause_in),
        .mtval_in    (mtval_in),
        .ext_irq     (ext_irq),
        .time_irq    (time_irq),
        .soft_irq    (soft_irq),
        .instr_retire(instr_retire),
        .mtvec_r     (mtvec_r),
        .mstatus_r   (mstatus_r),
        .mepc_r      (mepc_r),
        .mie_r       (mie_r)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] wd, input logic sz);
        bus.csr_op       = op;
        bus.csr_addr     = addr;
        bus.csr_wdata    = wd;
        bus.csr_src_zero = sz;
        #1;
        $display("txn op=%0d addr=%h wdata=%h sz=%0d -> rdata=%h illegal=%0d",
                 op, addr, wd, sz, bus.csr_rdata, bus.csr_illegal);
    endtask

    // Advance one clock and return the control inputs to idle.
    task automatic step();
        @(posedge clk);
        #1;
        bus.csr_op   = 2'b00;
        trap_en      = 1'b0;
        trap_return  = 1'b0;
        instr_retire = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        bus.csr_op = 2'b00; bus.csr_addr = 12'h0; bus.csr_wdata = 32'h0; bus.csr_src_zero = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_cmp++; if (mstatus_r !== 32'h0000_1800) begin n_bad++; $display("FAIL reset_mstatus: got %h want %h", mstatus_r, 32'h1800); end
        n_cmp++; if (mtvec_r !== 32'h0000_1000) begin n_bad++; $display("FAIL reset_mtvec: got %h want %h", mtvec_r, 32'h1000); end
        n_cmp++; if (mie_r !== 32'h0) begin n_bad++; $display("FAIL reset_mie: got %h want 0", mie_r); end
        n_cmp++; if (mepc_r !== 32'h0) begin n_bad++; $display("FAIL reset_mepc: got %h want 0", mepc_r); end
        drive(2'b10, 12'hB00, 32'h0, 1'b1);
        n_cmp++; if (bus.csr_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_mcycle: got %h want 0", bus.csr_rdata); end
        step();
        drive(2'b10, 12'hB00, 32'h0, 1'b1);
        n_cmp++; if (bus.csr_rdata !== 32'h1) begin n_bad++; $display("FAIL mcycle_inc1: got %h want 1", bus.csr_rdata); end
        step();
        drive(2'b10, 12'hB00, 32'h0, 1'b1);
        n_cmp++; if (bus.csr_rdata !== 32'h2) begin n_bad++; $display("FAIL mcycle_inc2: got %h want 2", bus.csr_rdata); end
        step();
    endtask

    task automatic test_rw();
        drive(2'b01, 12'h305, 32'h8000_0103, 1'b0);
        n_cmp++; if (bus.csr_rdata !== 32'h0000_1000) begin n_bad++; $display("FAIL mtvec_prewrite_read: got %h want %h", bus.csr_rdata, 32'h1000); end
        step();
        n_cmp++; if (mtvec_r !== 32'h8000_0101) begin n_bad++; $display("FAIL mtvec_rw: got %h want %h", mtvec_r, 32'h8000_0101); end
        drive(2'b10, 12'h300, 32'h8, 1'b0);
        n_cmp++; if (bus.csr_rdata !== 32'h1800) begin n_bad++; $display("FAIL mstatus_read: got %h want %h", bus.csr_rdata, 32'h1800); end
        step();
        n_cmp++; if (mstatus_r !== 32'h1808) begin n_bad++; $display("FAIL mstatus_rs: got %h want %h", mstatus_r, 32'h1808); end
        drive(2'b11, 12'h300, 32'h8, 1'b1);
        n_cmp++; if (bus.csr_illegal !== 1'b0) begin n_bad++; $display("FAIL rc_srczero_illegal: got %b want 0", bus.csr_illegal); end
        step();
        n_cmp++; if (mstatus_r !== 32'h1808) begin n_bad++; $display("FAIL rc_srczero_nowrite: got %h want %h", mstatus_r, 32'h1808); end
        drive(2'b01, 12'h300, 32'hFFFF_FFFF, 1'b0);
        step();
        n_cmp++; if (mstatus_r !== 32'h1888) begin n_bad++; $display("FAIL mstatus_mask: got %h want %h", mstatus_r, 32'h1888); end
        drive(2'b01, 12'h300, 32'h8, 1'b0);
        step();
        n_cmp++; if (mstatus_r !== 32'h1808) begin n_bad++; $display("FAIL mstatus_rw8: got %h want %h", mstatus_r, 32'h1808); end
        drive(2'b01, 12'h304, 32'hFFFF_FFFF, 1'b0);
        step();
        n_cmp++; if (mie_r !== 32'h888) begin n_bad++; $display("FAIL mie_mask: got %h want %h", mie_r, 32'h888); end
        drive(2'b11, 12'h304, 32'h8, 1'b0);
        step();
        n_cmp++; if (mie_r !== 32'h880) begin n_bad++; $display("FAIL mie_rc: got %h want %h", mie_r, 32'h880); end
        drive(2'b01, 12'h341, 32'hFFFF_FFFF, 1'b0);
        step();
        n_cmp++; if (mepc_r !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL mepc_mask: got %h want %h", mepc_r, 32'hFFFF_FFFC); end
        drive(2'b01, 12'h340, 32'hDEAD_BEEF, 1'b0);
        step();
        drive(2'b10, 12'h340, 32'h0, 1'b1);
        n_cmp++; if (bus.csr_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL mscratch: got %h want %h", bus.csr_rdata, 32'hDEAD_BEEF); end
        step();
    endtask

    task automatic test_trap();
        trap_en = 1'b1; mepc_in = 32'h0000_0106; mcause_in = 32'h8000_0007; mtval_in = 32'h0000_ABCD;
        step();
        n_cmp++; if (mepc_r !== 32'h0000_0104) begin n_bad++; $display("FAIL trap_mepc: got %h want %h", mepc_r, 32'h104); end
        n_cmp++; if (mstatus_r !== 32'h1880) begin n_bad++; $display("FAIL trap_mstatus: got %h want %h", mstatus_r, 32'h1880); end
        drive(2'b10, 12'h342, 32'h0, 1'b1);
        n_cmp++; if (bus.csr_rdata !== 32'h8000_0007) begin n_bad++; $display("FAIL trap_mcause: got %h want %h", bus.csr_rdata, 32'h8000_0007); end
        drive(2'b10, 12'h343, 32'h0, 1'b1);
        n_cmp++; if (bus.csr_rdata !== 32'h0000_ABCD) begin n_bad++; $display("FAIL trap_mtval: got %h want %h", bus.csr_rdata, 32'hABCD); end
        bus.csr_op = 2'b00;
        trap_return = 1'b1;
        step();
        n_cmp++; if (mstatus_r !== 32'h1888) begin n_bad++; $display("FAIL mret_mstatus: got %h want %h", mstatus_r, 32'h1888); end
        n_cmp++; if (mepc_r !== 32'h0000_0104) begin n_bad++; $display("FAIL mret_mepc: got %h want %h", mepc_r, 32'h104); end
    endtask

    task automatic test_trap_priority();
        trap_en = 1'b1; mepc_in = 32'h0000_0200; mcause_in = 32'h0000_000B; mtval_in = 32'h0;
        drive(2'b01, 12'h341, 32'h0, 1'b0);
        n_cmp++; if (bus.csr_rdata !== 32'h0000_0104) begin n_bad++; $display("FAIL prio_read: got %h want %h", bus.csr_rdata, 32'h104); end
        step();
        n_cmp++; if (mepc_r !== 32'h0000_0200) begin n_bad++; $display("FAIL prio_trap_mepc: got %h want %h", mepc_r, 32'h200); end
        n_cmp++; if (mstatus_r !== 32'h1880) begin n_bad++; $display("FAIL prio_trap_mstatus: got %h want %h", mstatus_r, 32'h1880); end
        trap_return = 1'b1;
        drive(2'b01, 12'h340, 32'h0, 1'b0);
        step();
        drive(2'b10, 12'h340, 32'h0, 1'b1);
        n_cmp++; if (bus.csr_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL prio_mret_drop: got %h want %h", bus.csr_rdata, 32'hDEAD_BEEF); end
        n_cmp++; if (mstatus_r !== 32'h1888) begin n_bad++; $display("FAIL prio_mret_mstatus: got %h want %h", mstatus_r, 32'h1888); end
        step();
    endtask

    task automatic test_counters();
        drive(2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0);
        step();
        drive(2'b01, 12'hB80, 32'h0, 1'b0);
        step();
        drive(2'b10, 12'hB00, 32'h0, 1'b1);
        n_cmp++; if (bus.csr_rdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mcycle_hold_on_write: got %h want %h", bus.csr_rdata, 32'hFFFF_FFFF); end
        step();
        drive(2'b10, 12'hB80, 32'h0, 1'b1);
        n_cmp++; if (bus.csr_rdata !== 32'h1) begin n_bad++; $display("FAIL mcycle_carry_hi: got %h want 1", bus.csr_rdata); end
        drive(2'b10, 12'hB00, 32'h0, 1'b1);
        n_cmp++; if (bus.csr_rdata !== 32'h0) begin n_bad++; $display("FAIL mcycle_carry_lo: got %h want 0", bus.csr_rdata); end
        step();
        instr_retire = 1'b1;
        drive(2'b01, 12'hB02, 32'h0000_1234, 1'b0);
        step();
        drive(2'b10, 12'hB02, 32'h0, 1'b1);
        n_cmp++; if (bus.csr_rdata !== 32'h0000_1234) begin n_bad++; $display("FAIL minstret_write_prio: got %h want %h", bus.csr_rdata, 32'h1234); end
        step();
        instr_retire = 1'b1;
        step();
        drive(2'b10, 12'hB02, 32'h0, 1'b1);
        n_cmp++; if (bus.csr_rdata !== 32'h0000_1235) begin n_bad++; $display("FAIL minstret_inc: got %h want %h", bus.csr_rdata, 32'h1235); end
        step();
        instr_retire = 1'b1; trap_en = 1'b1; mepc_in = 32'h0000_0300;
        step();
        trap_return = 1'b1;
        step();
        drive(2'b10, 12'hB02, 32'h0, 1'b1);
        n_cmp++; if (bus.csr_rdata !== 32'h0000_1235) begin n_bad++; $display("FAIL minstret_trap_block: got %h want %h", bus.csr_rdata, 32'h1235); end
        step();
        drive(2'b01, 12'hB02, 32'hFFFF_FFFF, 1'b0);
        step();
        instr_retire = 1'b1;
        step();
        drive(2'b10, 12'hB82, 32'h0, 1'b1);
        n_cmp++; if (bus.csr_rdata !== 32'h1) begin n_bad++; $display("FAIL minstret_carry_hi: got %h want 1", bus.csr_rdata); end
        drive(2'b10, 12'hB02, 32'h0, 1'b1);
        n_cmp++; if (bus.csr_rdata !== 32'h0) begin n_bad++; $display("FAIL minstret_carry_lo: got %h want 0", bus.csr_rdata); end
        step();
    endtask

    task automatic test_illegal();
        drive(2'b01, 12'h7C0, 32'h5, 1'b0);
        n_cmp++; if (bus.csr_illegal !== 1'b1) begin n_bad++; $display("FAIL unmapped_illegal: got %b want 1", bus.csr_illegal); end
        n_cmp++; if (bus.csr_rdata !== 32'h0) begin n_bad++; $display("FAIL unmapped_rdata: got %h want 0", bus.csr_rdata); end
        step();
        n_cmp++; if (mtvec_r !== 32'h8000_0101) begin n_bad++; $display("FAIL unmapped_nochange: got %h want %h", mtvec_r, 32'h8000_0101); end
        drive(2'b10, 12'h7C0, 32'h0, 1'b1);
        n_cmp++; if (bus.csr_illegal !== 1'b1) begin n_bad++; $display("FAIL unmapped_read_illegal: got %b want 1", bus.csr_illegal); end
        drive(2'b01, 12'hF14, 32'h5, 1'b0);
        n_cmp++; if (bus.csr_illegal !== 1'b1) begin n_bad++; $display("FAIL hartid_write_illegal: got %b want 1", bus.csr_illegal); end
        n_cmp++; if (bus.csr_rdata !== 32'h0) begin n_bad++; $display("FAIL hartid_write_rdata: got %h want 0", bus.csr_rdata); end
        drive(2'b10, 12'hF14, 32'h0, 1'b1);
        n_cmp++; if (bus.csr_illegal !== 1'b0) begin n_bad++; $display("FAIL hartid_read_illegal: got %b want 0", bus.csr_illegal); end
        n_cmp++; if (bus.csr_rdata !== 32'h3) begin n_bad++; $display("FAIL hartid_read: got %h want 3", bus.csr_rdata); end
        drive(2'b11, 12'hF12, 32'h1, 1'b0);
        n_cmp++; if (bus.csr_illegal !== 1'b1) begin n_bad++; $display("FAIL id_rc_illegal: got %b want 1", bus.csr_illegal); end
        drive(2'b00, 12'h7C0, 32'h5, 1'b0);
        n_cmp++; if (bus.csr_illegal !== 1'b0) begin n_bad++; $display("FAIL opnone_illegal: got %b want 0", bus.csr_illegal); end
        drive(2'b01, 12'h301, 32'h0, 1'b0);
        n_cmp++; if (bus.csr_illegal !== 1'b0) begin n_bad++; $display("FAIL misa_write_illegal: got %b want 0", bus.csr_illegal); end
        step();
        drive(2'b10, 12'h301, 32'h0, 1'b1);
        n_cmp++; if (bus.csr_rdata !== 32'h4000_0100) begin n_bad++; $display("FAIL misa_warl: got %h want %h", bus.csr_rdata, 32'h4000_0100); end
        step();
    endtask

    task automatic test_mip();
        time_irq = 1'b1;
        drive(2'b10, 12'h344, 32'h0, 1'b1);
        n_cmp++; if (bus.csr_rdata !== 32'h0) begin n_bad++; $display("FAIL mip_latency: got %h want 0", bus.csr_rdata); end
        step();
        drive(2'b10, 12'h344, 32'h0, 1'b1);
        n_cmp++; if (bus.csr_rdata !== 32'h80) begin n_bad++; $display("FAIL mip_mtip: got %h want %h", bus.csr_rdata, 32'h80); end
        ext_irq = 1'b1; soft_irq = 1'b1;
        step();
        drive(2'b01, 12'h344, 32'h0, 1'b0);
        n_cmp++; if (bus.csr_illegal !== 1'b0) begin n_bad++; $display("FAIL mip_write_illegal: got %b want 0", bus.csr_illegal); end
        n_cmp++; if (bus.csr_rdata !== 32'h888) begin n_bad++; $display("FAIL mip_all: got %h want %h", bus.csr_rdata, 32'h888); end
        step();
        drive(2'b10, 12'h344, 32'h0, 1'b1);
        n_cmp++; if (bus.csr_rdata !== 32'h888) begin n_bad++; $display("FAIL mip_write_ignored: got %h want %h", bus.csr_rdata, 32'h888); end
        time_irq = 1'b0; ext_irq = 1'b0; soft_irq = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        drive(2'b01, 12'h340, 32'h1, 1'b0);
        n_cmp++; if (bus.csr_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL b2b_rw: got %h want %h", bus.csr_rdata, 32'hDEAD_BEEF); end
        step();
        drive(2'b10, 12'h340, 32'h2, 1'b0);
        n_cmp++; if (bus.csr_rdata !== 32'h1) begin n_bad++; $display("FAIL b2b_rs: got %h want 1", bus.csr_rdata); end
        step();
        drive(2'b11, 12'h340, 32'h1, 1'b0);
        n_cmp++; if (bus.csr_rdata !== 32'h3) begin n_bad++; $display("FAIL b2b_rc: got %h want 3", bus.csr_rdata); end
        step();
        drive(2'b10, 12'h340, 32'h0, 1'b1);
        n_cmp++; if (bus.csr_rdata !== 32'h2) begin n_bad++; $display("FAIL b2b_final: got %h want 2", bus.csr_rdata); end
        step();
    endtask

    task automatic test_reset_mid();
        drive(2'b01, 12'h305, 32'h0000_0044, 1'b0);
        #2 rst = 1'b1;
        #1;
        bus.csr_op = 2'b00;
        n_cmp++; if (mtvec_r !== 32'h0000_1000) begin n_bad++; $display("FAIL midreset_mtvec: got %h want %h", mtvec_r, 32'h1000); end
        n_cmp++; if (mstatus_r !== 32'h1800) begin n_bad++; $display("FAIL midreset_mstatus: got %h want %h", mstatus_r, 32'h1800); end
        n_cmp++; if (mie_r !== 32'h0) begin n_bad++; $display("FAIL midreset_mie: got %h want 0", mie_r); end
        n_cmp++; if (mepc_r !== 32'h0) begin n_bad++; $display("FAIL midreset_mepc: got %h want 0", mepc_r); end
        @(posedge clk);
        #1 rst = 1'b0;
        drive(2'b10, 12'h340, 32'h0, 1'b1);
        n_cmp++; if (bus.csr_rdata !== 32'h0) begin n_bad++; $display("FAIL midreset_mscratch: got %h want 0", bus.csr_rdata); end
        step();
        n_cmp++; if (mtvec_r !== 32'h0000_1000) begin n_bad++; $display("FAIL midreset_write_lost: got %h want %h", mtvec_r, 32'h1000); end
    endtask

    initial begin
        test_reset();
        test_rw();
        test_trap();
        test_trap_priority();
        test_counters();
        test_illegal();
        test_mip();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
